ifu_ysyx: RTL and testbench

IFU_YSYX -- requirements
Module: ifu_ysyx

---
 rtl/ifu_ysyx_pkg.sv | 15 +
 rtl/ifu_ysyx.sv | 110 +++++++++++
 tb/tb_ifu_ysyx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ifu_ysyx_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, reset PC default and the NOP word
// that is substituted for a fetch that cannot be issued.
package ifu_ysyx_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NEXT = 2'd3
    } ifu_state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

endpackage

// File: rtl/ifu_ysyx.sv
// Single-outstanding instruction fetch: request, wait for the word, hold it for decode, wait for the commit pulse.
// Latency 2 cycles from request accept to inst_valid; IFU_YSYX_MISALIGN_CHECK_EN turns misaligned PCs into a faulting NOP.
module ifu_ysyx
    import ifu_ysyx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_upd_valid,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    ifu_state_t state;
    logic       req_valid;

    assign imem_req_valid = req_valid;
    assign imem_addr      = pc;

`ifdef IFU_YSYX_MISALIGN_CHECK_EN
    logic fault;
    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
`ifdef IFU_YSYX_MISALIGN_CHECK_EN
            fault      <= 1'b0;
            req_valid  <= (RESET_PC[1:0] == 2'b00);
`else
            req_valid  <= 1'b1;
`endif
        end else begin
            unique case (state)
                S_REQ: begin
`ifdef IFU_YSYX_MISALIGN_CHECK_EN
                    // A misaligned PC never reaches memory; decode sees a NOP tagged with the fault.
                    if (pc[1:0] != 2'b00) begin
                        inst       <= IFU_NOP;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        fault      <= 1'b1;
                        req_valid  <= 1'b0;
                        state      <= S_OUT;
                    end else if (imem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
`else
                    if (imem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
`endif
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        inst       <= imem_resp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
`ifdef IFU_YSYX_MISALIGN_CHECK_EN
                        fault      <= 1'b0;
`endif
                        state      <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (pc_upd_valid) begin
                        pc    <= next_pc;
                        state <= S_REQ;
`ifdef IFU_YSYX_MISALIGN_CHECK_EN
                        req_valid <= (next_pc[1:0] == 2'b00);
`else
                        req_valid <= 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= S_REQ;
                    req_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_ysyx.sv
// Directed bench for ifu_ysyx: reset, normal fetch, decode stall, commit filtering,
// request stall, mid-transaction reset and misaligned next PC.
module tb_ifu_ysyx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_upd_valid;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    ifu_ysyx dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc_upd_valid   (pc_upd_valid),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        next_pc         = '0;
        pc_upd_valid    = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        tick();
        tick();

        check("rst_pc",          pc,          32'h8000_0000);
        check("rst_inst",        inst,        32'h0);
        check("rst_inst_pc",     inst_pc,     32'h0);
        check("rst_inst_valid",  inst_valid,  32'h0);
        check("rst_fetch_fault", fetch_fault, 32'h0);

        // Basic fetch: accept immediately, response the next cycle.
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        check("first_req_valid", imem_req_valid, 32'h1);
        check("first_req_addr",  imem_addr,      32'h8000_0000);
        tick();
        check("wait_req_low",   imem_req_valid, 32'h0);
        check("wait_no_inst",   inst_valid,     32'h0);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0297;
        tick();
        check("out_inst_valid", inst_valid, 32'h1);
        check("out_inst",       inst,       32'h0000_0297);
        check("out_inst_pc",    inst_pc,    32'h8000_0000);

        // Decode stall with a commit pulse and a stray response that must both be ignored.
        imem_resp_data = 32'hDEAD_BEEF;
        pc_upd_valid   = 1'b1;
        next_pc        = 32'h8000_0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst_valid", inst_valid,     32'h1);
            check("stall_inst",       inst,           32'h0000_0297);
            check("stall_inst_pc",    inst_pc,        32'h8000_0000);
            check("stall_no_req",     imem_req_valid, 32'h0);
            check("stall_pc",         pc,             32'h8000_0000);
        end
        imem_resp_valid = 1'b0;
        pc_upd_valid    = 1'b0;
        inst_ready      = 1'b1;
        tick();
        check("next_inst_valid", inst_valid, 32'h0);
        inst_ready = 1'b0;
        tick();
        check("next_wait_no_req", imem_req_valid, 32'h0);
        check("next_wait_pc",     pc,             32'h8000_0000);
        pc_upd_valid = 1'b1;
        tick();
        pc_upd_valid = 1'b0;
        check("upd_pc",        pc,             32'h8000_0100);
        check("upd_req_valid", imem_req_valid, 32'h1);
        check("upd_req_addr",  imem_addr,      32'h8000_0100);

        // Memory not ready for 3 cycles: request must hold steady.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_req_valid", imem_req_valid, 32'h1);
            check("hold_req_addr",  imem_addr,      32'h8000_0100);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("hold_accept_req_low", imem_req_valid, 32'h0);
        check("hold_accept_no_inst", inst_valid,     32'h0);

        // Reset in S_WAIT, then a stale response while back in S_REQ.
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        check("midrst_pc",         pc,         32'h8000_0000);
        check("midrst_inst_valid", inst_valid, 32'h0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        check("stale_req_valid",  imem_req_valid, 32'h1);
        check("stale_req_addr",   imem_addr,      32'h8000_0000);
        check("stale_inst_valid", inst_valid,     32'h0);
        check("stale_inst",       inst,           32'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0073;
        tick();
        imem_resp_valid = 1'b0;
        check("refetch_inst_valid", inst_valid, 32'h1);
        check("refetch_inst",       inst,       32'h0010_0073);
        check("refetch_inst_pc",    inst_pc,    32'h8000_0000);

        // Misaligned next PC.
        inst_ready = 1'b1;
        tick();
        inst_ready   = 1'b0;
        pc_upd_valid = 1'b1;
        next_pc      = 32'h8000_0102;
        tick();
        pc_upd_valid = 1'b0;
        check("mis_pc", pc, 32'h8000_0102);
`ifdef IFU_YSYX_MISALIGN_CHECK_EN
        check("mis_no_req", imem_req_valid, 32'h0);
        tick();
        check("mis_no_req_out", imem_req_valid, 32'h0);
        check("mis_inst_valid", inst_valid,     32'h1);
        check("mis_fault",      fetch_fault,    32'h1);
        check("mis_inst",       inst,           32'h0000_0013);
        check("mis_inst_pc",    inst_pc,        32'h8000_0102);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("mis_fault_clear", fetch_fault, 32'h0);
        check("mis_valid_clear", inst_valid,  32'h0);
`else
        check("mis_req_valid", imem_req_valid, 32'h1);
        check("mis_req_addr",  imem_addr,      32'h8000_0102);
        check("mis_fault",     fetch_fault,    32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
